// File: rtl/data_mem_arbiter_if.sv
// Bundle of both requester ports and the DataMemory pins around data_mem_arbiter.
// slave is the arbiter side; master is the side that drives requests and models memory.
interface data_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              ack0;
  logic              err0;
  logic [DATA_W-1:0] rdata0;

  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              ack1;
  logic              err1;
  logic [DATA_W-1:0] rdata1;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_write;
  logic              mem_read;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rdata,
    output ack0, err0, rdata0, ack1, err1, rdata1,
    output mem_addr, mem_wdata, mem_write, mem_read
  );

  modport master (
    output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rdata,
    input  ack0, err0, rdata0, ack1, err1, rdata1,
    input  mem_addr, mem_wdata, mem_write, mem_read
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one single-port DataMemory between two req/ack requesters.
// Each grant costs an ACCESS cycle (memory pins active) followed by a RESP cycle (ack).
module data_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic               clk,
  input logic               rst_n,
  data_mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state, state_next;
  logic              gnt, rr_ptr, we_q, err_q;
  logic              elig0, elig1, grant_valid, grant_port;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_we, sel_aligned;

  // The port being acked in RESP is masked so the other port can go straight to ACCESS.
  always_comb begin
    elig0       = bus.req0 && !(state == RESP && gnt == 1'b0);
    elig1       = bus.req1 && !(state == RESP && gnt == 1'b1);
    grant_valid = (state != ACCESS) && (elig0 || elig1);
    grant_port  = (elig0 && elig1) ? rr_ptr : elig1;
    sel_addr    = grant_port ? bus.addr1  : bus.addr0;
    sel_wdata   = grant_port ? bus.wdata1 : bus.wdata0;
    sel_we      = grant_port ? bus.we1    : bus.we0;
    sel_aligned = (sel_addr[1:0] == 2'b00);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_valid) state_next = ACCESS;
      ACCESS:  state_next = RESP;
      RESP:    state_next = grant_valid ? ACCESS : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt           <= 1'b0;
      rr_ptr        <= 1'b0;
      we_q          <= 1'b0;
      err_q         <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_write <= 1'b0;
      bus.mem_read  <= 1'b0;
      bus.rdata0    <= '0;
      bus.rdata1    <= '0;
    end else begin
      if (grant_valid) begin
        gnt           <= grant_port;
        rr_ptr        <= ~grant_port;
        we_q          <= sel_we;
        err_q         <= ~sel_aligned;
        bus.mem_addr  <= sel_addr;
        bus.mem_wdata <= sel_wdata;
        bus.mem_write <= sel_we & sel_aligned;
        bus.mem_read  <= ~sel_we & sel_aligned;
      end else begin
        bus.mem_addr  <= '0;
        bus.mem_wdata <= '0;
        bus.mem_write <= 1'b0;
        bus.mem_read  <= 1'b0;
      end
      // Misaligned requests report zero data whether they were reads or writes.
      if (state == ACCESS && (!we_q || err_q)) begin
        if (gnt) bus.rdata1 <= err_q ? '0 : bus.mem_rdata;
        else     bus.rdata0 <= err_q ? '0 : bus.mem_rdata;
      end
    end
  end

  always_comb begin
    bus.ack0 = (state == RESP) && (gnt == 1'b0);
    bus.ack1 = (state == RESP) && (gnt == 1'b1);
    bus.err0 = bus.ack0 && err_q;
    bus.err1 = bus.ack1 && err_q;
  end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a small word-addressed DataMemory model.
module tb_data_mem_arbiter;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [31:0] mem [0:63];

  data_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  data_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sentinel when not reading, so a misaligned capture of mem_rdata would be visible.
  always_comb bus.mem_rdata = bus.mem_read ? mem[bus.mem_addr[7:2]] : 32'hBAD0_BAD0;

  always @(posedge clk)
    if (bus.mem_write) mem[bus.mem_addr[7:2]] <= bus.mem_wdata;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int port, input logic req, input logic we,
                               input logic [31:0] addr, input logic [31:0] wdata);
    if (port == 0) begin
      bus.req0 = req; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata;
    end else begin
      bus.req1 = req; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
    applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    int acks;
    int writes;
    int ack_seen;
    checks = 0;
    errors = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i;
    doReset();

    checkOutput("rst_ack0", bus.ack0, 0);
    checkOutput("rst_ack1", bus.ack1, 0);
    checkOutput("rst_err0", bus.err0, 0);
    checkOutput("rst_rdata0", bus.rdata0, 0);
    checkOutput("rst_rdata1", bus.rdata1, 0);
    checkOutput("rst_mem_write", bus.mem_write, 0);
    checkOutput("rst_mem_read", bus.mem_read, 0);
    checkOutput("rst_mem_addr", bus.mem_addr, 0);

    // Test 1: port 0 write, then port 1 read back
    applyStimulus(0, 1'b1, 1'b1, 32'h4, 32'hAAAA_AAAA);
    tick();
    checkOutput("t1_mem_write", bus.mem_write, 1);
    checkOutput("t1_mem_addr", bus.mem_addr, 32'h4);
    checkOutput("t1_mem_wdata", bus.mem_wdata, 32'hAAAA_AAAA);
    checkOutput("t1_ack0_early", bus.ack0, 0);
    tick();
    checkOutput("t1_ack0", bus.ack0, 1);
    checkOutput("t1_err0", bus.err0, 0);
    checkOutput("t1_mem_write_off", bus.mem_write, 0);
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("t1_ack0_pulse", bus.ack0, 0);
    applyStimulus(1, 1'b1, 1'b0, 32'h4, 32'h0);
    tick();
    checkOutput("t1_mem_read", bus.mem_read, 1);
    tick();
    checkOutput("t1_ack1", bus.ack1, 1);
    checkOutput("t1_rdata1", bus.rdata1, 32'hAAAA_AAAA);
    checkOutput("t1_err1", bus.err1, 0);
    applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();

    // Test 2: simultaneous requests after reset
    doReset();
    applyStimulus(0, 1'b1, 1'b0, 32'h4, 32'h0);
    applyStimulus(1, 1'b1, 1'b0, 32'h10, 32'h0);
    tick();
    checkOutput("t2_c1_addr", bus.mem_addr, 32'h4);
    checkOutput("t2_c1_read", bus.mem_read, 1);
    tick();
    checkOutput("t2_c2_ack0", bus.ack0, 1);
    checkOutput("t2_c2_ack1", bus.ack1, 0);
    checkOutput("t2_c2_rdata0", bus.rdata0, 32'hAAAA_AAAA);
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("t2_c3_addr", bus.mem_addr, 32'h10);
    checkOutput("t2_c3_ack0", bus.ack0, 0);
    tick();
    checkOutput("t2_c4_ack1", bus.ack1, 1);
    checkOutput("t2_c4_rdata1", bus.rdata1, 32'h1000_0004);
    applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("t2_c5_ack1", bus.ack1, 0);

    // Test 3: both held for 8 accesses, grants must alternate starting at port 0
    doReset();
    applyStimulus(0, 1'b1, 1'b0, 32'h20, 32'h0);
    applyStimulus(1, 1'b1, 1'b0, 32'h24, 32'h0);
    n = 0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (bus.mem_read) begin
        checkOutput("t3_grant_addr", bus.mem_addr, (n % 2 == 1) ? 32'h24 : 32'h20);
        n++;
      end
    end
    checkOutput("t3_access_count", n, 8);
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
    applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();

    // Test 4: misaligned read on port 1
    applyStimulus(1, 1'b1, 1'b0, 32'h6, 32'h0);
    tick();
    checkOutput("t4_mem_read", bus.mem_read, 0);
    checkOutput("t4_mem_write", bus.mem_write, 0);
    tick();
    checkOutput("t4_ack1", bus.ack1, 1);
    checkOutput("t4_err1", bus.err1, 1);
    checkOutput("t4_rdata1", bus.rdata1, 0);
    checkOutput("t4_mem_read_resp", bus.mem_read, 0);
    applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("t4_err1_after", bus.err1, 0);

    // Test 5: three back-to-back writes on port 0 alone
    applyStimulus(0, 1'b1, 1'b1, 32'h30, 32'h0000_00D0);
    acks = 0;
    writes = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (bus.mem_write) writes++;
      if (bus.ack0) begin
        checkOutput("t5_ack_cycle", k, 3 * acks + 2);
        acks++;
        if (acks == 1)      applyStimulus(0, 1'b1, 1'b1, 32'h34, 32'h0000_00D1);
        else if (acks == 2) applyStimulus(0, 1'b1, 1'b1, 32'h38, 32'h0000_00D2);
        else                applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
      end
    end
    checkOutput("t5_ack_count", acks, 3);
    checkOutput("t5_write_count", writes, 3);
    checkOutput("t5_mem30", mem[12], 32'h0000_00D0);
    checkOutput("t5_mem34", mem[13], 32'h0000_00D1);
    checkOutput("t5_mem38", mem[14], 32'h0000_00D2);

    // Test 6: reset during ACCESS drops the write and restores port 0 priority
    applyStimulus(0, 1'b1, 1'b1, 32'h8, 32'hDEAD_BEEF);
    tick();
    checkOutput("t6_mem_write", bus.mem_write, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_write_cleared", bus.mem_write, 0);
    checkOutput("t6_addr_cleared", bus.mem_addr, 0);
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ack_seen = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (bus.ack0) ack_seen++;
    end
    checkOutput("t6_no_ack0", ack_seen, 0);
    applyStimulus(0, 1'b1, 1'b0, 32'h8, 32'h0);
    applyStimulus(1, 1'b1, 1'b0, 32'hC, 32'h0);
    tick();
    checkOutput("t6_rr_port0_first", bus.mem_addr, 32'h8);
    tick();
    checkOutput("t6_ack0", bus.ack0, 1);
    checkOutput("t6_rdata0", bus.rdata0, 32'h1000_0002);
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    checkOutput("t6_ack1", bus.ack1, 1);
    checkOutput("t6_rdata1", bus.rdata1, 32'h1000_0003);
    applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
Shares the single-port DataMemory between two requesters: port 0 (CPU load/store path) and port 1 (debug/DMA loader). Round-robin arbitration, one memory access per grant, and a req/ack handshake per port. Sits between the requesters and the DataMemory Address/WriteData/MemWrite/MemRead/ReadData pins. DataMemory writes on the rising clk edge when MemWrite=1; ReadData is combinational from Address while MemRead=1.

Parameters:
ADDR_W, 32, address width of requesters and memory
DATA_W, 32, data width

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req0  input  1  port 0 request; held high with we0/addr0/wdata0 stable until ack0
we0  input  1  port 0: 1=write, 0=read
addr0  input  ADDR_W  port 0 byte address
wdata0  input  DATA_W  port 0 write data
ack0  output  1  port 0 one-cycle completion pulse
err0  output  1  port 0 error flag, valid with ack0
rdata0  output  DATA_W  port 0 read data, valid with ack0
req1, we1, addr1, wdata1, ack1, err1, rdata1  same as port 0, for port 1
mem_addr  output  ADDR_W  to DataMemory Address
mem_wdata  output  DATA_W  to DataMemory WriteData
mem_write  output  1  to DataMemory MemWrite
mem_read  output  1  to DataMemory MemRead
mem_rdata  input  DATA_W  from DataMemory ReadData

Behaviour:
- Clock/reset: one clock, clk. rst_n is asynchronous and active-low.
- States: IDLE, ACCESS, RESP. Reset puts the FSM in IDLE.
- Reset values: ack*/err* = 0, rdata* = 0, mem_* = 0, rr_ptr = 0 (port 0 favoured), gnt = 0.
- Arbitration: evaluated in IDLE and in RESP.
  - Only one eligible request: grant it.
  - Both requesting: grant port rr_ptr.
  - On each grant: rr_ptr <= ~granted port.
- Acked-port mask: in RESP, the port whose ack is high is masked from arbitration.
  - Back-to-back on the same port costs one extra IDLE cycle.
  - The other port may be granted directly RESP->ACCESS.
- Transitions:
  - IDLE -> ACCESS on a grant, else stay in IDLE.
  - ACCESS -> RESP always.
  - RESP -> ACCESS on a grant, else IDLE.
- Memory-side outputs: registered, loaded on entry to ACCESS from the granted port's signals.
  - Active exactly one cycle (the ACCESS cycle).
  - mem_write = we & aligned; mem_read = ~we & aligned.
  - Outside ACCESS: mem_write = mem_read = 0; mem_addr and mem_wdata hold 0.
- Alignment: aligned means addr[1:0] == 2'b00. A misaligned request:
  - completes with the same latency;
  - drives mem_write = mem_read = 0 during ACCESS;
  - returns err = 1 and rdata = 0 with ack.
- Read capture: at the end of ACCESS, mem_rdata is registered into the granted port's rdata. The other port's rdata is unchanged.
- For writes, rdata of the granted port is unchanged.
- Ack: in RESP, ack of the granted port = 1 for exactly one cycle. err is valid only while ack = 1, else 0.
- Latency: req sampled at edge N (IDLE) -> memory access in cycle N+1 -> ack in cycle N+2. Sustained throughput is one access per 2 cycles.
- Requester contract: may drop req in the ack cycle. Changing the request fields before ack is a protocol violation; the arbiter uses the values latched at grant.
- Reset mid-operation: rst_n low immediately clears mem_write/mem_read. An in-flight write in ACCESS is dropped, no ack is issued, and the FSM returns to IDLE.

Test Plan:
1. After reset, port 0 writes addr 0x4, data 0xAAAA_AAAA -> mem_write=1 for exactly one cycle with mem_addr=0x4; ack0=1 two cycles after req sampled; err0=0. Then port 1 reads 0x4 -> rdata1=0xAAAA_AAAA with ack1, err1=0.
2. req0 and req1 rise in the same cycle after reset -> port 0 gets ACCESS in cycle 1 and ack0 in cycle 2. Port 1 gets ACCESS in cycle 3 (direct from RESP) and ack1 in cycle 4.
3. Both requests held high for 8 accesses -> grant order 0,1,0,1,0,1,0,1; no two consecutive grants to the same port.
4. Port 1 read at misaligned addr 0x6 -> mem_read and mem_write stay 0 throughout; ack1=1 with err1=1 and rdata1=0 at the normal latency.
5. Only port 0 requesting, 3 back-to-back writes -> ack0 pulses spaced 3 cycles apart (the masked RESP cycle forces IDLE); no duplicate memory write.
6. Port 0 write to 0x8 with rst_n pulsed low during ACCESS -> mem_write falls immediately, no ack0. A subsequent read of 0x8 returns the pre-existing value; rr_ptr = 0 after reset.
